// File: rtl/spm_loader.sv
// Byte-stream program loader: receives a length-prefixed word stream and writes it into the SPM,
// then enables the CPU. Define SPM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module spm_loader #(
    parameter int SPM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data,
    output logic        cpu_en,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_BYTE,
        S_WRITE,
        S_RUN,
        S_ERR
`ifdef SPM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t      state_q, state_d;
    state_t      done_state;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] n_q, n_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] n_new;
    logic        accepting;
    logic        accept;
    logic        last_word;

`ifdef SPM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    assign done_state = S_CSUM;
`else
    assign done_state = S_RUN;
`endif

    always_comb begin
        accepting = 1'b0;
        case (state_q)
            S_LEN0, S_LEN1, S_BYTE: accepting = 1'b1;
`ifdef SPM_LOADER_CHECKSUM_EN
            S_CSUM:                 accepting = 1'b1;
`endif
            default:                accepting = 1'b0;
        endcase
    end

    // Outputs are gated by reset so nothing is accepted or strobed during the reset cycle.
    assign rx_ready    = accepting && !reset;
    assign accept      = rx_valid && rx_ready;
    assign spm_as_     = !((state_q == S_WRITE) && !reset);
    assign spm_rw      = (state_q == S_WRITE) && !reset;
    assign spm_addr    = addr_q;
    assign spm_wr_data = wdata_q;
    assign cpu_en      = (state_q == S_RUN);
    assign err         = (state_q == S_ERR);
`ifdef SPM_LOADER_CHECKSUM_EN
    assign busy        = (state_q == S_LEN1) || (state_q == S_BYTE) ||
                         (state_q == S_WRITE) || (state_q == S_CSUM);
`else
    assign busy        = (state_q == S_LEN1) || (state_q == S_BYTE) || (state_q == S_WRITE);
`endif

    assign n_new     = {rx_data, len_lo_q};
    assign last_word = ({1'b0, idx_q} + 17'd1) == {1'b0, n_q};

    // Each incoming byte lands in the lane selected by the running byte count.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_d[gi*8 +: 8] = (state_q == S_BYTE && accept && cnt_q == 2'(gi))
                                   ? rx_data : word_q[gi*8 +: 8];
    end

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef SPM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        if (accept && state_q != S_CSUM) begin
            csum_d = csum_q ^ rx_data;
        end
`endif
        case (state_q)
            S_LEN0: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    n_d = n_new;
                    if ({16'd0, n_new} > 32'(SPM_DEPTH)) begin
                        state_d = S_ERR;
                    end else if (n_new == 16'd0) begin
                        state_d = done_state;
                    end else begin
                        idx_d   = 16'd0;
                        cnt_d   = 2'd0;
                        state_d = S_BYTE;
                    end
                end
            end
            S_BYTE: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        addr_d  = {14'd0, idx_q};
                        wdata_d = word_d;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // The index stops at N-1 once the final word has been written.
                if (last_word) begin
                    state_d = done_state;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = S_BYTE;
                end
            end
`ifdef SPM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_LEN0;
            len_lo_q <= 8'd0;
            n_q      <= 16'd0;
            idx_q    <= 16'd0;
            cnt_q    <= 2'd0;
            word_q   <= 32'd0;
            addr_q   <= 30'd0;
            wdata_q  <= 32'd0;
`ifdef SPM_LOADER_CHECKSUM_EN
            csum_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef SPM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_spm_loader.sv
// Directed bench for spm_loader: expected SPM writes are queued as bytes are driven and
// popped by a strobe monitor; status outputs are checked at fixed points.
module tb_spm_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic        cpu_en;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [7:0]  tb_csum;
    logic [61:0] sb_q[$];

    always #5 clk = ~clk;

    spm_loader #(.SPM_DEPTH(4096)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .cpu_en(cpu_en), .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every low spm_as_ cycle must match the head of the scoreboard.
    initial begin
        logic [61:0] e;
        forever begin
            @(negedge clk);
            if (spm_as_ === 1'b0) begin
                chk("strobe_rw", {31'd0, spm_rw}, 32'd1);
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe_addr", {2'd0, spm_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe_addr", {2'd0, spm_addr}, {2'd0, e[61:32]});
                    chk("strobe_data", spm_wr_data, e[31:0]);
                    $display("write addr=%0d data=%h", spm_addr, spm_wr_data);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rx_ready === 1'b1) break;
            n++;
            if (n > 100) begin
                chk("ready_timeout", {31'd0, rx_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        tb_csum  = tb_csum ^ b;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [29:0] addr, input logic [31:0] w, input int gap);
        sb_q.push_back({addr, w});
        for (int i = 0; i < 4; i++) send(w[i*8 +: 8], gap);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_as", {31'd0, spm_as_}, 32'd1);
        @(posedge clk);
        #1;
        chk("rst_outputs", {spm_rw, cpu_en, err, busy}, 32'd0);
        chk("rst_addr", {2'd0, spm_addr}, 32'd0);
        chk("rst_data", spm_wr_data, 32'd0);
        reset   = 1'b0;
        tb_csum = 8'd0;
        #1;
        chk("idle_ready", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic finish_stream();
`ifdef SPM_LOADER_CHECKSUM_EN
        @(posedge clk);
        #1;
        chk("csum_cpu_en_low", {31'd0, cpu_en}, 32'd0);
        send(tb_csum, 0);
`else
        @(posedge clk);
        #1;
`endif
        chk("run_cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("run_busy_err", {busy, err}, 32'd0);
    endtask

    task automatic idle_bytes(input int cycles);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("ignored_ready", {31'd0, rx_ready}, 32'd0);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tb_csum  = 8'd0;
        do_reset();

        // Single word; cpu_en rises one cycle after the strobe.
        send(8'h01, 0);
        send(8'h00, 0);
        chk("busy_loading", {31'd0, busy}, 32'd1);
        send_word(30'd0, 32'h0FF0_0093, 0);
        chk("strobe_cycle_as", {31'd0, spm_as_}, 32'd0);
        chk("strobe_cycle_cpu_en", {31'd0, cpu_en}, 32'd0);
        finish_stream();
        idle_bytes(3);
        chk("hold_addr", {2'd0, spm_addr}, 32'd0);
        chk("hold_data", spm_wr_data, 32'h0FF0_0093);
        chk("sb_empty_1", sb_q.size(), 32'd0);
        $display("test single_word done");

        // Three words with one idle cycle between bytes.
        do_reset();
        send(8'h03, 1);
        send(8'h00, 1);
        send_word(30'd0, 32'h0000_0013, 1);
        send_word(30'd1, 32'h0010_0093, 1);
        send_word(30'd2, 32'h0020_0113, 1);
        finish_stream();
        chk("hold_addr_3", {2'd0, spm_addr}, 32'd2);
        chk("hold_data_3", spm_wr_data, 32'h0020_0113);
        chk("sb_empty_2", sb_q.size(), 32'd0);
        $display("test three_words done");

        // Length beyond SPM_DEPTH.
        do_reset();
        send(8'h01, 0);
        send(8'h10, 0);
        chk("oversize_err", {31'd0, err}, 32'd1);
        chk("oversize_cpu_en", {31'd0, cpu_en}, 32'd0);
        idle_bytes(3);
        chk("oversize_err_held", {cpu_en, err}, 32'd1);
        $display("test oversize done");

        // Length exactly SPM_DEPTH is legal: still loading after LEN.
        do_reset();
        send(8'h00, 0);
        send(8'h10, 0);
        chk("depth_ok_busy", {err, busy}, 32'd1);

`ifdef SPM_LOADER_CHECKSUM_EN
        do_reset();
        send(8'h01, 0);
        send(8'h00, 0);
        send_word(30'd0, 32'h1234_5678, 0);
        @(posedge clk);
        #1;
        send(8'h00, 0);
        chk("bad_csum_err", {cpu_en, err}, 32'd1);
        $display("test bad_checksum done");
`endif

        // Reset in the middle of word 1 discards it.
        do_reset();
        send(8'h02, 0);
        send(8'h00, 0);
        send_word(30'd0, 32'hDEAD_BEEF, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        do_reset();
        send(8'h01, 0);
        send(8'h00, 0);
        send_word(30'd0, 32'h0000_0013, 0);
        finish_stream();
        chk("sb_empty_3", sb_q.size(), 32'd0);
        $display("test mid_load_reset done");

        // Zero-length stream.
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
`ifdef SPM_LOADER_CHECKSUM_EN
        send(tb_csum, 0);
`endif
        chk("zero_len_cpu_en", {31'd0, cpu_en}, 32'd1);
        idle_bytes(4);
        chk("zero_len_held", {cpu_en, err}, 32'd2);
        chk("sb_empty_4", sb_q.size(), 32'd0);
        $display("test zero_length done");

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
